regfile_wb_arbiter: RTL and testbench

//  Two-requester writeback arbiter for the 32x64 register file's single write port.

---
 rtl/regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single write port of the 32x64 register file between two
//   writeback requesters: requester 0 (execute-stage result) and requester 1
//   (load / NIC-receive result). Each requester owns a one-entry holding slot.
//   Occupied slots are granted round-robin into a registered output stage that
//   drives wrEn/wrAddr/dataIn/ppp. A pending-write mask is exported so decode
//   can detect hazards against writes that have not yet reached the regfile.
//
// Ports
//   clk                 clock, all state updates on posedge
//   reset               asynchronous active-high reset, clears all state
//   reqN_valid          requester N offers a write
//   reqN_ready          slot N can accept a write this cycle
//   reqN_addr           requester N destination register
//   reqN_data           requester N write data
//   reqN_ppp            requester N field select (000 a,001 u,010 d,011 e,100 o)
//   wrEn                regfile write enable (registered, one cycle per write)
//   wrAddr              regfile write address (registered)
//   dataIn              regfile write data (registered)
//   ppp                 regfile field select (registered)
//   pend_mask           bit r set while a write to r sits in a slot or output stage
//   err_ppp             one-cycle pulse when a write is dropped for an illegal ppp
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [0:ADDR_WIDTH-1] req0_addr,
   input  logic [0:DATA_WIDTH-1] req0_data,
   input  logic [0:2]            req0_ppp,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [0:ADDR_WIDTH-1] req1_addr,
   input  logic [0:DATA_WIDTH-1] req1_data,
   input  logic [0:2]            req1_ppp,
   output logic                  wrEn,
   output logic [0:ADDR_WIDTH-1] wrAddr,
   output logic [0:DATA_WIDTH-1] dataIn,
   output logic [0:2]            ppp,
   output logic [0:DEPTH-1]      pend_mask,
   output logic                  err_ppp
);

   // Field selects 000..100 name a real register field; 101..111 are dropped.
   function automatic logic ppp_legal(input logic [0:2] sel);
      return (sel <= 3'd4);
   endfunction

   // Register 0 is hard-wired; writes to it are consumed without effect.
   function automatic logic addr_live(input logic [0:ADDR_WIDTH-1] a);
      return (a != {ADDR_WIDTH{1'b0}});
   endfunction

   logic [1:0]            slot_vld_r;
   logic [0:ADDR_WIDTH-1] slot_addr_r [2];
   logic [0:DATA_WIDTH-1] slot_data_r [2];
   logic [0:2]            slot_ppp_r  [2];
   // 1 when the most recent grant went to slot 1, so slot 0 wins a tie next.
   logic                  last_grant_r;

   logic                  grant0_s;
   logic                  grant1_s;
   logic                  any_grant_s;
   logic [0:ADDR_WIDTH-1] sel_addr_s;
   logic [0:DATA_WIDTH-1] sel_data_s;
   logic [0:2]            sel_ppp_s;
   logic [1:0]            accept_s;
   logic [1:0]            in_valid_s;
   logic [0:ADDR_WIDTH-1] in_addr_s [2];
   logic [0:DATA_WIDTH-1] in_data_s [2];
   logic [0:2]            in_ppp_s  [2];
   logic [0:DEPTH-1]      pend_s;

   assign in_valid_s   = {req1_valid, req0_valid};
   assign in_addr_s[0] = req0_addr;
   assign in_addr_s[1] = req1_addr;
   assign in_data_s[0] = req0_data;
   assign in_data_s[1] = req1_data;
   assign in_ppp_s[0]  = req0_ppp;
   assign in_ppp_s[1]  = req1_ppp;

   // Round-robin arbitration over occupied slots.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      case (slot_vld_r)
         2'b01: grant0_s = 1'b1;
         2'b10: grant1_s = 1'b1;
         2'b11: begin
            if (last_grant_r) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end
         default: begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      endcase
   end

   assign any_grant_s = grant0_s | grant1_s;
   assign sel_addr_s  = grant1_s ? slot_addr_r[1] : slot_addr_r[0];
   assign sel_data_s  = grant1_s ? slot_data_r[1] : slot_data_r[0];
   assign sel_ppp_s   = grant1_s ? slot_ppp_r[1]  : slot_ppp_r[0];

   // A slot being drained this cycle can be refilled on the same edge.
   assign req0_ready  = ~slot_vld_r[0] | grant0_s;
   assign req1_ready  = ~slot_vld_r[1] | grant1_s;
   assign accept_s    = {req1_valid & req1_ready, req0_valid & req0_ready};

   // Holding slots: load on handshake, empty when granted without a refill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_vld_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            slot_addr_r[i] <= {ADDR_WIDTH{1'b0}};
            slot_data_r[i] <= {DATA_WIDTH{1'b0}};
            slot_ppp_r[i]  <= 3'b000;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (accept_s[i] && in_valid_s[i]) begin
               slot_vld_r[i]  <= 1'b1;
               slot_addr_r[i] <= in_addr_s[i];
               slot_data_r[i] <= in_data_s[i];
               slot_ppp_r[i]  <= in_ppp_s[i];
            end else if ((i == 0 && grant0_s) || (i == 1 && grant1_s)) begin
               slot_vld_r[i]  <= 1'b0;
            end else begin
               slot_vld_r[i]  <= slot_vld_r[i];
            end
         end
      end
   end

   // Remember the last granted slot for round-robin fairness.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_r <= 1'b1;
      end else if (any_grant_s) begin
         last_grant_r <= grant1_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   // Output stage: capture the granted slot; dropped writes still update the
   // address/data/ppp outputs but never raise wrEn.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrEn    <= 1'b0;
         wrAddr  <= {ADDR_WIDTH{1'b0}};
         dataIn  <= {DATA_WIDTH{1'b0}};
         ppp     <= 3'b000;
         err_ppp <= 1'b0;
      end else if (any_grant_s) begin
         wrEn    <= addr_live(sel_addr_s) & ppp_legal(sel_ppp_s);
         wrAddr  <= sel_addr_s;
         dataIn  <= sel_data_s;
         ppp     <= sel_ppp_s;
         err_ppp <= ~ppp_legal(sel_ppp_s);
      end else begin
         wrEn    <= 1'b0;
         err_ppp <= 1'b0;
      end
   end

   // Pending-write scoreboard: occupied slots plus a live output-stage write.
   always_comb begin
      pend_s = {DEPTH{1'b0}};
      for (int i = 0; i < 2; i++) begin
         if (slot_vld_r[i] && addr_live(slot_addr_r[i])) begin
            pend_s[slot_addr_r[i]] = 1'b1;
         end else begin
            pend_s = pend_s;
         end
      end
      if (wrEn) begin
         pend_s[wrAddr] = 1'b1;
      end else begin
         pend_s = pend_s;
      end
   end

   assign pend_mask = pend_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [0:4]  req0_addr, req1_addr;
   logic [0:63] req0_data, req1_data;
   logic [0:2]  req0_ppp, req1_ppp;
   logic        wrEn;
   logic [0:4]  wrAddr;
   logic [0:63] dataIn;
   logic [0:2]  ppp;
   logic [0:31] pend_mask;
   logic        err_ppp;

   int checks   = 0;
   int failures = 0;

   // reference model: per-requester held write, last winner, output record
   bit          m_full [2];
   int          m_addr [2];
   logic [63:0] m_data [2];
   int          m_ppp  [2];
   int          m_last;
   bit          m_we, m_err;
   int          m_wa, m_wp;
   logic [63:0] m_wd;

   regfile_wb_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .DEPTH(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_ppp(req0_ppp),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_ppp(req1_ppp),
      .wrEn(wrEn), .wrAddr(wrAddr), .dataIn(dataIn), .ppp(ppp),
      .pend_mask(pend_mask), .err_ppp(err_ppp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int winner();
      if (m_full[0] && m_full[1]) return (m_last == 1) ? 0 : 1;
      else if (m_full[0]) return 0;
      else if (m_full[1]) return 1;
      else return -1;
   endfunction

   function automatic bit model_ready(input int n);
      return !m_full[n] || (winner() == n);
   endfunction

   function automatic logic [0:31] model_pend();
      logic [0:31] e;
      e = '0;
      for (int i = 0; i < 2; i++) if (m_full[i] && m_addr[i] != 0) e[m_addr[i]] = 1'b1;
      if (m_we) e[m_wa] = 1'b1;
      return e;
   endfunction

   task automatic model_clear();
      m_full[0] = 0; m_full[1] = 0; m_last = 1;
      m_we = 0; m_err = 0; m_wa = 0; m_wp = 0; m_wd = '0;
   endtask

   // advance the model across one clock edge using the inputs the DUT sampled
   task automatic model_edge();
      int w;
      bit r0, r1;
      w  = winner();
      r0 = model_ready(0);
      r1 = model_ready(1);
      if (w >= 0) begin
         m_wa = m_addr[w]; m_wd = m_data[w]; m_wp = m_ppp[w];
         m_we = (m_wa != 0) && (m_wp < 5);
         m_err = (m_wp >= 5);
         m_last = w;
      end else begin
         m_we = 0; m_err = 0;
      end
      if (req0_valid && r0) begin
         m_full[0] = 1; m_addr[0] = int'(req0_addr); m_data[0] = req0_data; m_ppp[0] = int'(req0_ppp);
      end else if (w == 0) m_full[0] = 0;
      if (req1_valid && r1) begin
         m_full[1] = 1; m_addr[1] = int'(req1_addr); m_data[1] = req1_data; m_ppp[1] = int'(req1_ppp);
      end else if (w == 1) m_full[1] = 0;
   endtask

   task automatic compare_all();
      check("wrEn",   64'(wrEn),      64'(m_we));
      check("err_ppp",64'(err_ppp),   64'(m_err));
      check("ready0", 64'(req0_ready),64'(model_ready(0)));
      check("ready1", 64'(req1_ready),64'(model_ready(1)));
      check("pend",   64'(pend_mask), 64'(model_pend()));
      if (m_we || m_err) begin
         check("wrAddr", 64'(wrAddr), 64'(m_wa));
         check("dataIn", dataIn,       m_wd);
         check("ppp",    64'(ppp),     64'(m_wp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit v0, input int a0, input logic [63:0] d0, input int p0,
                        input bit v1, input int a1, input logic [63:0] d1, input int p1);
      req0_valid = v0; req0_addr = 5'(a0); req0_data = d0; req0_ppp = 3'(p0);
      req1_valid = v1; req1_addr = 5'(a1); req1_data = d1; req1_ppp = 3'(p1);
   endtask

   task automatic idle();
      drive(0, 0, 64'd0, 0, 0, 0, 64'd0, 0);
   endtask

   task automatic apply_reset();
      #1 reset = 1'b1;
      idle();
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_clear();
      @(posedge clk);
      #1;
      check("rst_wrEn", 64'(wrEn), 64'd0);
      check("rst_wrAddr", 64'(wrAddr), 64'd0);
      check("rst_dataIn", dataIn, 64'd0);
      check("rst_ppp", 64'(ppp), 64'd0);
      check("rst_pend", 64'(pend_mask), 64'd0);
      check("rst_ready0", 64'(req0_ready), 64'd1);
      reset = 1'b0;

      // single write
      drive(1, 5, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 64'd0, 0);
      step();
      idle();
      check("t1_pend5_a", 64'(pend_mask[5]), 64'd1);
      check("t1_wrEn_early", 64'(wrEn), 64'd0);
      step();
      check("t1_wrEn", 64'(wrEn), 64'd1);
      check("t1_addr", 64'(wrAddr), 64'd5);
      check("t1_data", dataIn, 64'hDEAD_BEEF_0123_4567);
      check("t1_pend5_b", 64'(pend_mask[5]), 64'd1);
      step();
      check("t1_pend5_c", 64'(pend_mask[5]), 64'd0);

      // contention, alternating grants starting with req0
      apply_reset();
      drive(1, 3, 64'h3333, 0, 1, 7, 64'h7777, 0);
      step();
      for (int k = 0; k < 6; k++) begin
         step();
         check("t2_wrEn", 64'(wrEn), 64'd1);
         check("t2_addr", 64'(wrAddr), (k % 2 == 0) ? 64'd3 : 64'd7);
         check("t2_ready1", 64'(req1_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      end
      idle();
      step(); step(); step();

      // drops: addr 0 silently, illegal ppp with error pulse
      apply_reset();
      drive(1, 0, 64'h1, 0, 0, 0, 64'd0, 0);
      step();
      idle();
      step();
      check("t4_addr0_wrEn", 64'(wrEn), 64'd0);
      check("t4_addr0_err", 64'(err_ppp), 64'd0);
      drive(0, 0, 64'd0, 0, 1, 9, 64'h9999, 5);
      step();
      idle();
      check("t4_pend9_set", 64'(pend_mask[9]), 64'd1);
      step();
      check("t4_err", 64'(err_ppp), 64'd1);
      check("t4_wrEn", 64'(wrEn), 64'd0);
      check("t4_pend9_clr", 64'(pend_mask[9]), 64'd0);
      step();
      check("t4_err_pulse", 64'(err_ppp), 64'd0);

      // partial-field writes pass data unmasked
      drive(1, 12, 64'hFEDC_BA98_7654_3210, 3, 0, 0, 64'd0, 0);
      step();
      drive(1, 12, 64'h0123_4567_89AB_CDEF, 4, 0, 0, 64'd0, 0);
      step();
      idle();
      check("t5_ppp_e", 64'(ppp), 64'd3);
      check("t5_data_e", dataIn, 64'hFEDC_BA98_7654_3210);
      step();
      check("t5_ppp_o", 64'(ppp), 64'd4);
      check("t5_wrEn_o", 64'(wrEn), 64'd1);
      check("t5_data_o", dataIn, 64'h0123_4567_89AB_CDEF);
      step();

      // asynchronous reset with both slots full and a write in the output stage
      drive(1, 3, 64'hA, 0, 1, 7, 64'hB, 0);
      step();
      step();
      #2 reset = 1'b1;
      #1;
      check("t6_wrEn", 64'(wrEn), 64'd0);
      check("t6_pend", 64'(pend_mask), 64'd0);
      check("t6_ready0", 64'(req0_ready), 64'd1);
      check("t6_ready1", 64'(req1_ready), 64'd1);
      model_clear();
      @(posedge clk);
      #1 reset = 1'b0;
      step();
      step();
      check("t6_first_grant", 64'(wrAddr), 64'd3);
      idle();
      step(); step(); step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         req0_valid = ($urandom_range(0, 9) < 7);
         req1_valid = ($urandom_range(0, 9) < 7);
         req0_addr  = 5'($urandom_range(0, 7));
         req1_addr  = 5'($urandom_range(0, 7));
         req0_data  = {$urandom, $urandom};
         req1_data  = {$urandom, $urandom};
         req0_ppp   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         req1_ppp   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
